// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC interrupt gateway.
package plic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    INSERVICE
  } gw_state_e;

  function automatic int unsigned edge_cnt_width(input int unsigned max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/plic_gateway_cell.sv
// One gateway source: request FSM, saturating edge counter and edge detector.
module plic_gateway_cell
  import plic_pkg::*;
#(
  parameter int unsigned MaxEdgeCnt = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  input  logic le_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic ip_o
);

  localparam int unsigned CntW = edge_cnt_width(MaxEdgeCnt);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxEdgeCnt);

  gw_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            irq_q;
  logic            edge_det;
  logic            req;
  logic            take;

  always_comb begin
    edge_det = le_i & irq_i & ~irq_q;
    req      = le_i ? (cnt_q != '0) : irq_i;
    take     = (state_q == IDLE) & req;

    state_d = state_q;
    unique case (state_q)
      IDLE:      if (req)        state_d = PENDING;
      PENDING:   if (claim_i)    state_d = INSERVICE;
      INSERVICE: if (complete_i) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase

    // A new edge in the same cycle as the consuming transition cancels the decrement.
    cnt_d = cnt_q;
    if (!le_i) begin
      cnt_d = '0;
    end else if (take && edge_det) begin
      cnt_d = cnt_q;
    end else if (take) begin
      cnt_d = cnt_q - CntW'(1);
    end else if (edge_det && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_i;
    end
  end

  assign ip_o = (state_q == PENDING);

endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: one cell per source 1..NumSource, bit 0 tied off.
// Define PLIC_GATEWAY_SYNC_EN to pass irq_i through a two-flop synchronizer.
module plic_gateway
  import plic_pkg::*;
#(
  parameter int unsigned NumSource  = 31,
  parameter int unsigned MaxEdgeCnt = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumSource:0]   irq_i,
  input  logic [NumSource:0]   le_i,
  input  logic [NumSource:0]   claim_i,
  input  logic [NumSource:0]   complete_i,
  output logic [NumSource:0]   ip_o
);

  logic [NumSource:0] irq_s;

`ifdef PLIC_GATEWAY_SYNC_EN
  logic [NumSource:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_i;
`endif

  for (genvar k = 1; k <= NumSource; k++) begin : g_cell
    plic_gateway_cell #(
      .MaxEdgeCnt(MaxEdgeCnt)
    ) u_cell (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .irq_i      (irq_s[k]),
      .le_i       (le_i[k]),
      .claim_i    (claim_i[k]),
      .complete_i (complete_i[k]),
      .ip_o       (ip_o[k])
    );
  end

  assign ip_o[0] = 1'b0;

  logic unused_src0;
  assign unused_src0 = ^{irq_s[0], le_i[0], claim_i[0], complete_i[0]};

`ifndef SYNTHESIS
  max_edge_cnt_a: assert property (@(posedge clk_i) MaxEdgeCnt >= 1);
`endif

endmodule

// File: tb/tb_plic_gateway.sv
// Directed self-checking bench for plic_gateway.
module tb_plic_gateway;

`ifdef PLIC_GATEWAY_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] irq_i;
  logic [31:0] le_i;
  logic [31:0] claim_i;
  logic [31:0] complete_i;
  logic [31:0] ip_o;

  int errors = 0;
  int checks = 0;

  plic_gateway #(
    .NumSource  (31),
    .MaxEdgeCnt (3)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .irq_i      (irq_i),
    .le_i       (le_i),
    .claim_i    (claim_i),
    .complete_i (complete_i),
    .ip_o       (ip_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_claim(input int k);
    claim_i[k] = 1'b1;
    tick();
    claim_i[k] = 1'b0;
  endtask

  task automatic pulse_complete(input int k);
    complete_i[k] = 1'b1;
    tick();
    complete_i[k] = 1'b0;
  endtask

  initial begin
    rst_i      = 1'b1;
    irq_i      = '0;
    le_i       = 32'h0000_0070;
    claim_i    = '0;
    complete_i = '0;
    #1;
    check("reset_ip", ip_o, 32'h0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    check("post_reset_ip", ip_o, 32'h0);

    // Level source 3
    irq_i[3] = 1'b1;
    tick();
    check("lvl_pend", ip_o, 32'h0000_0008);
    pulse_claim(3);
    check("lvl_claim", ip_o[3], 1'b0);
    pulse_complete(3);
    check("lvl_idle", ip_o[3], 1'b0);
    tick();
    check("lvl_repend", ip_o[3], 1'b1);
    pulse_claim(3);
    irq_i[3] = 1'b0;
    pulse_complete(3);
    tick();
    tick();
    check("lvl_drop", ip_o[3], 1'b0);
    irq_i[3] = 1'b1;
    tick();
    irq_i[3] = 1'b0;
    tick();
    tick();
    check("lvl_no_retract", ip_o[3], 1'b1);
    pulse_claim(3);
    pulse_complete(3);
    tick();
    check("lvl_clean", ip_o[3], 1'b0);

    // Level latency through the optional synchronizer
    irq_i[8] = 1'b1;
    for (int i = 0; i < SyncLat; i++) begin
      tick();
      check("sync_wait", ip_o[8], 1'b0);
    end
    tick();
    check("sync_pend", ip_o[8], 1'b1);
    irq_i[8] = 1'b0;
    for (int i = 0; i < SyncLat; i++) tick();
    pulse_claim(8);
    pulse_complete(8);
    tick();

    // Edge source 5: saturation at MaxEdgeCnt
    irq_i[5] = 1'b1;
    tick();
    check("edge_lat1", ip_o[5], 1'b0);
    irq_i[5] = 1'b0;
    tick();
    check("edge_lat2", ip_o[5], 1'b1);
    pulse_claim(5);
    check("edge_claim", ip_o[5], 1'b0);
    for (int i = 0; i < 5; i++) begin
      irq_i[5] = 1'b1;
      tick();
      irq_i[5] = 1'b0;
      tick();
    end
    check("edge_insvc", ip_o[5], 1'b0);
    for (int r = 0; r < 3; r++) begin
      pulse_complete(5);
      check("edge_round_idle", ip_o[5], 1'b0);
      tick();
      check("edge_round_pend", ip_o[5], 1'b1);
      pulse_claim(5);
    end
    pulse_complete(5);
    tick();
    tick();
    check("edge_sat_exhausted", ip_o[5], 1'b0);

    // Edge source 6: edge coincident with the IDLE->PENDING decrement
    irq_i[6] = 1'b1;
    tick();
    irq_i[6] = 1'b0;
    tick();
    pulse_claim(6);
    irq_i[6] = 1'b1;
    tick();
    irq_i[6] = 1'b0;
    tick();
    pulse_complete(6);
    irq_i[6] = 1'b1;
    tick();
    irq_i[6] = 1'b0;
    check("coinc_pend1", ip_o[6], 1'b1);
    pulse_claim(6);
    pulse_complete(6);
    tick();
    check("coinc_pend2", ip_o[6], 1'b1);
    pulse_claim(6);
    pulse_complete(6);
    tick();
    tick();
    check("coinc_none", ip_o[6], 1'b0);

    // Spurious pulses on source 7 and source 0
    irq_i[7] = 1'b1;
    tick();
    pulse_complete(7);
    check("spur_complete_pend", ip_o[7], 1'b1);
    pulse_claim(7);
    irq_i[7] = 1'b0;
    pulse_complete(7);
    pulse_claim(7);
    check("spur_claim_idle", ip_o[7], 1'b0);
    irq_i[7] = 1'b1;
    tick();
    check("spur_still_idle", ip_o[7], 1'b1);
    pulse_claim(7);
    irq_i[7] = 1'b0;
    pulse_complete(7);
    irq_i[0]   = 1'b1;
    claim_i[0] = 1'b1;
    le_i[0]    = 1'b1;
    tick();
    claim_i[0] = 1'b0;
    tick();
    check("src0_tied", ip_o, 32'h0);
    irq_i[0] = 1'b0;
    le_i[0]  = 1'b0;

    // Asynchronous reset with sources 1, 2, 4 busy
    irq_i[1] = 1'b1;
    irq_i[2] = 1'b1;
    irq_i[4] = 1'b1;
    tick();
    irq_i[4]   = 1'b0;
    claim_i[2] = 1'b1;
    tick();
    claim_i[2] = 1'b0;
    irq_i[4]   = 1'b1;
    tick();
    check("pre_rst_ip", ip_o, 32'h0000_0012);
    irq_i[1] = 1'b0;
    irq_i[2] = 1'b0;
    rst_i    = 1'b1;
    #2;
    check("rst_async", ip_o, 32'h0);
    #2;
    rst_i = 1'b0;
    tick();
    check("rst_edge_lat", ip_o, 32'h0);
    tick();
    check("rst_edge_pend", ip_o, 32'h0000_0010);
    pulse_claim(4);
    pulse_complete(4);
    tick();
    tick();
    check("rst_cnt_cleared", ip_o[4], 1'b0);
    check("final_ip", ip_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
